// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so idle-high lines come out of reset quietly.
module sync2 #(
  parameter logic RST = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first one a full cycle to settle.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RST;
      q    <= RST;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_meter.sv
// One-shot high-pulse width meter with a saturating inline counter.
// Armed by arm, measures the next rising-to-falling pulse seen on in.
module pulse_meter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  input  logic         arm,
  output logic [W-1:0] width,
  output logic         valid,
  output logic         over,
  output logic         busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  localparam logic [W-1:0] MAX = '1;

  logic         s;
  logic         p;
  logic         rise;
  logic         fall;
  logic [1:0]   state;
  logic [1:0]   nxt;
  logic [W-1:0] count;
  logic         ovf;

  // Reset high so a line already high at release shows no edge.
  sync2 #(.RST(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (in),
    .q     (s)
  );

  // Previous synchronized level, for edge detection.
  always_ff @(posedge clock) begin
    if (reset) p <= 1'b1;
    else       p <= s;
  end

  assign rise = s & ~p;
  assign fall = ~s & p;

  // Next-state decode; also feeds the registered busy flag.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (arm)  nxt = ARMED;
      ARMED:   if (rise) nxt = MEASURE;
      MEASURE: if (fall) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Measurement datapath, result registers and state update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
      width <= '0;
      valid <= 1'b0;
      over  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= (nxt != IDLE);
      valid <= 1'b0;
      case (state)
        ARMED: begin
          if (rise) count <= {{(W-1){1'b0}}, 1'b1};
        end
        MEASURE: begin
          if (fall) begin
            width <= count;
            over  <= ovf;
            valid <= 1'b1;
            ovf   <= 1'b0;
          end else if (s) begin
            if (count == MAX) ovf <= 1'b1;
            else              count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: directed scenarios then random pulses.
// Expected results come from pulse lengths, saturated at 2^W-1.
module tb_pulse_meter;

  localparam int W   = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         in;
  logic         arm;
  logic [W-1:0] width;
  logic         valid;
  logic         over;
  logic         busy;

  typedef struct {
    int w;
    bit o;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  pulse_meter #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .arm   (arm),
    .width (width),
    .valid (valid),
    .over  (over),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Monitor: every valid pops one expected result.
  always @(negedge clock) begin
    if (!reset && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("width", int'(width), e.w);
        chk("over", int'(over), int'(e.o));
        chk("valid_cycle", cyc, e.c);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
  endtask

  // High pulse of n cycles; queue its expected measurement if armed.
  task automatic pulse(int n, bit expect_it);
    exp_t e;
    in = 1'b1;
    repeat (n) @(negedge clock);
    in = 1'b0;
    if (expect_it) begin
      e.w = (n > MAXV) ? MAXV : n;
      e.o = (n > MAXV);
      e.c = cyc + 3;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in    = 1'b0;
    arm   = 1'b0;
    idle(3);
    chk("rst_width", int'(width), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_over", int'(over), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    idle(3);

    // Basic 10-cycle measurement.
    do_arm();
    chk("busy_armed", int'(busy), 1);
    idle(1);
    pulse(10, 1'b1);
    idle(5);
    chk("busy_after", int'(busy), 0);
    chk("width_hold10", int'(width), 10);

    // Pulse already high at arm time is skipped.
    in = 1'b1;
    idle(4);
    do_arm();
    idle(4);
    in = 1'b0;
    idle(3);
    pulse(4, 1'b1);
    idle(5);

    // Saturation, then overflow is cleared for the next run.
    do_arm();
    idle(1);
    pulse(300, 1'b1);
    idle(5);
    do_arm();
    idle(1);
    pulse(7, 1'b1);
    idle(5);

    // Second pulse without re-arm is ignored.
    do_arm();
    idle(1);
    pulse(3, 1'b1);
    idle(3);
    pulse(9, 1'b0);
    idle(6);
    chk("width_hold3", int'(width), 3);
    chk("busy_noarm", int'(busy), 0);

    // Reset in the middle of a measurement.
    do_arm();
    idle(1);
    in = 1'b1;
    idle(8);
    reset = 1'b1;
    idle(1);
    chk("mid_rst_width", int'(width), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_over", int'(over), 0);
    chk("mid_rst_busy", int'(busy), 0);
    reset = 1'b0;
    idle(2);
    in = 1'b0;
    idle(3);
    do_arm();
    idle(1);
    pulse(1, 1'b1);
    idle(5);

    // Arm accepted in the valid cycle.
    do_arm();
    idle(1);
    pulse(5, 1'b1);
    idle(3);
    chk("valid_now", int'(valid), 1);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    chk("busy_rearm", int'(busy), 1);
    idle(1);
    pulse(2, 1'b1);
    idle(5);

    // Random mix of armed, pre-high and unarmed pulses.
    for (int i = 0; i < 40; i++) begin
      int kind;
      int n;
      kind = $urandom_range(0, 3);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 270)
                                      : $urandom_range(1, 20);
      if (kind == 0) begin
        pulse(n, 1'b0);
      end else if (kind == 1) begin
        in = 1'b1;
        idle(3);
        do_arm();
        idle($urandom_range(0, 3));
        in = 1'b0;
        idle($urandom_range(1, 4));
        pulse(n, 1'b1);
      end else begin
        do_arm();
        idle($urandom_range(0, 4));
        pulse(n, 1'b1);
      end
      idle($urandom_range(4, 8));
      chk("rand_busy", int'(busy), 0);
    end

    idle(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
